// File: rtl/half_adder_if.sv
// Operand/result bundle for the registered multi-lane half adder.
// The master drives the addends A/B; the slave returns the per-lane sum/carry.
interface half_adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;

  modport master (output A, output B, input sum, input carry);
  modport slave  (input A, input B, output sum, output carry);
endinterface

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with registered sum/carry.
// Both outputs share one register stage, so they always change together.
module half_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  half_adder_if.slave  bus
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;

  // Lanes are bitwise, so no carry ever crosses from one lane into the next.
  always_comb begin
    sum_c   = bus.A ^ bus.B;
    carry_c = bus.A & bus.B;
  end

  // Synchronous reset drops the operand pair sampled on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.sum   <= '0;
      bus.carry <= '0;
    end else begin
      bus.sum   <= sum_c;
      bus.carry <= carry_c;
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder at WIDTH = 1, 4 and 8, all fed from one stimulus stream.
// Stimulus queues the expected result per cycle; a negedge monitor pops and compares.
module tb_half_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  half_adder_if #(.WIDTH(1)) if1 ();
  half_adder_if #(.WIDTH(4)) if4 ();
  half_adder_if #(.WIDTH(8)) if8 ();

  assign if1.A = a[0:0];
  assign if1.B = b[0:0];
  assign if4.A = a[3:0];
  assign if4.B = b[3:0];
  assign if8.A = a;
  assign if8.B = b;

  half_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  half_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  half_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  typedef struct {
    int         due;
    string      tag;
    logic [7:0] s;
    logic [7:0] c;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: results are due one edge after the operands were applied.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      exp_t stale;
      stale = q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: expected result for cyc %0d never checked", stale.tag, stale.due);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      check({e.tag, " w1.sum"},   {7'b0, if1.sum},   {7'b0, e.s[0]});
      check({e.tag, " w1.carry"}, {7'b0, if1.carry}, {7'b0, e.c[0]});
      check({e.tag, " w4.sum"},   {4'b0, if4.sum},   {4'b0, e.s[3:0]});
      check({e.tag, " w4.carry"}, {4'b0, if4.carry}, {4'b0, e.c[3:0]});
      check({e.tag, " w8.sum"},   if8.sum,   e.s);
      check({e.tag, " w8.carry"}, if8.carry, e.c);
      check({e.tag, " w8.exclusive"}, if8.sum & if8.carry, 8'h00);
    end
  end

  // Apply one operand pair just after an edge; its result is due after the next edge.
  task automatic drive(input string tag, input logic r, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] es, input logic [7:0] ec);
    @(posedge clk);
    #1;
    rst_n = r;
    a = av;
    b = bv;
    q.push_back('{cyc + 1, tag, es, ec});
  endtask

  // Inputs bounce before settling; only the settled pair may reach the outputs.
  task automatic drive_glitch(input string tag, input logic [7:0] av, input logic [7:0] bv,
                              input logic [7:0] es, input logic [7:0] ec);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    #1;
    a = 8'hA5;
    b = 8'h3C;
    #1;
    a = av;
    b = bv;
    q.push_back('{cyc + 1, tag, es, ec});
  endtask

  initial begin
    logic [7:0] ra, rb, rs, rc;
    logic [1:0] t;

    // Reset held two cycles with all operands at 1.
    drive("rst0", 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);
    drive("rst1", 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);

    // Truth table; first edge out of reset registers (0,0).
    drive("tt00", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive("tt10", 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00);
    drive("tt11", 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF);
    drive("tt01", 1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00);

    // Lane independence: low nibble 1100+1010, high nibble 0101+0011.
    drive("lanes", 1'b1, 8'h5C, 8'h3A, 8'h66, 8'h18);

    // Latency: sum stays 0 until the edge that captures A=1.
    drive("lat0", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    drive("lat1", 1'b1, 8'h01, 8'h00, 8'h01, 8'h00);

    // Glitching inputs between edges while the previous result is being held.
    drive_glitch("glitch", 8'h00, 8'h0F, 8'h0F, 8'h00);
    drive("hold", 1'b1, 8'h0F, 8'h0F, 8'h00, 8'h0F);

    // Mid-stream reset for one edge on a 1+1 stream.
    drive("mid0", 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF);
    drive("midr", 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);
    drive("mid1", 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF);

    // Random lanes; expected per lane is the 2-bit arithmetic sum A[i]+B[i].
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        t = 2'({1'b0, ra[i]}) + 2'({1'b0, rb[i]});
        rs[i] = t[0];
        rc[i] = t[1];
      end
      drive("rand", 1'b1, ra, rb, rs, rc);
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 4 && q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results still pending, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
